wb_merge_unit: RTL and testbench
================================

# wb_merge_unit

Parametrised writeback stage for the pipelined RV32 core. It merges the in-order pipeline's writeback with results from up to NUM_LQ long-latency units (mul/div, non-blocking loads) into the single register-file write port. It adds RV32I sub-word load extraction, a buffered FIFO per long-latency channel, round-robin draining, and a starvation guard that stalls the pipeline for one cycle. It sits between the MEM/WB pipeline register and the register file.

## Interface
- XLEN, 32, data width
- NUM_LQ, 2, number of long-latency result channels (1..4)
- LQ_DEPTH, 2, entries per channel FIFO (power of 2, ≥2)
- STARVE_LIMIT, 4, consecutive cycles a nonempty FIFO may be denied before a forced stall (≥1)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wb_alu_out_in  in  XLEN  ALU result
- wb_mem_data_in  in  XLEN  raw load word from data memory
- wb_pc4_in  in  XLEN  PC+4 (JAL/JALR)
- wb_imm_in  in  XLEN  immediate (LUI)
- wb_rd_in  in  5  destination register
- wb_reg_in_sel_in  in  2  00/01 ALU, 10 imm, 11 pc4
- wb_mem_reg_in  in  1  select load data
- wb_mem_funct3_in  in  3  load funct3
- wb_addr_lo_in  in  2  load address bits [1:0]
- wb_reg_wr_in  in  1  pipeline write request
- lq_valid_in  in  NUM_LQ  per-channel result valid
- lq_data_in  in  NUM_LQ*XLEN  flattened results; channel i at [i*XLEN +: XLEN]
- lq_rd_in  in  NUM_LQ*5  flattened destinations
- lq_ready_out  out  NUM_LQ  channel FIFO not full
- wb_rd_out  out  5  register-file write address
- wb_reg_wr_data_out  out  XLEN  register-file write data
- wb_reg_wr_out  out  1  register-file write enable
- wb_src_out  out  3  0 = pipeline, i+1 = channel i (for scoreboard clear)
- wb_stall_out  out  1  pipeline must hold its WB inputs this cycle

## Operation
- Pipeline data:
  - if wb_mem_reg_in, the extracted load is written;
  - else reg_in_sel selects ALU (00/01), imm (10) or pc4 (11).
- Load extraction by funct3:
  - 000 LB: byte at addr_lo, sign-extended;
  - 100 LBU: byte at addr_lo, zero-extended;
  - 001 LH: half at addr_lo[1], sign-extended;
  - 101 LHU: half at addr_lo[1], zero-extended;
  - 010 and all other codes: full word.
  - addr_lo[0] is ignored for halfwords; misalignment traps upstream.
- Per-channel FIFO:
  - push when lq_valid_in[i] && lq_ready_out[i];
  - lq_ready_out[i] = !full, even if a pop occurs the same cycle (no push-on-pop when full);
  - results with rd=0 are accepted but not stored.
- Pipeline request (preq) = wb_reg_wr_in && wb_rd_in != 0. With rd=0, write enable is 0 and the slot is free.
- Arbitration, each cycle:
  - force = (starve_cnt == STARVE_LIMIT) && any FIFO nonempty;
  - preq && !force: pipeline writes, wb_src_out = 0;
  - else if any FIFO is nonempty: round-robin grant starting at rr_ptr; the granted head pops and is written; rr_ptr ← grant+1 mod NUM_LQ;
  - else no write (wb_reg_wr_out = 0, rd/data outputs = pipeline values).
- wb_stall_out = force && preq. The pipeline holds MEM/WB stable, and the held write goes through next cycle (force is clear by then).
- starve_cnt:
  - resets to 0 on any FIFO grant or when all FIFOs are empty;
  - else increments while any FIFO is nonempty and preq wins;
  - saturates at STARVE_LIMIT.
- The hazard unit guarantees that no younger instruction targets an rd still in flight in a channel, so no WAW check is done here.

## Timing
- Pipeline path is combinational: inputs to write port in the same cycle.
- Channel path:
  - push at edge N, eligible for write in cycle N+1 at the earliest (no bypass);
  - per-channel results are written in push order.
- Reset (rst high at an edge): FIFOs empty, rr_ptr = 0, starve_cnt = 0.
- While rst is high: wb_reg_wr_out = 0, wb_stall_out = 0, lq_ready_out = 0.
- Reset mid-operation discards all buffered entries. The scoreboard is reset by the same rst.
- Simultaneous push to an empty FIFO and grant in the same cycle: the grant sees the FIFO as empty; the entry is written the following cycle.

## Test plan
- Pipeline only, funct3=000, addr_lo=2, mem_data=0x12F45678, mem_reg=1, rd=5 → same-cycle write x5 = 0xFFFFFFF4. With funct3=101, addr_lo=2 → 0x000012F4. With sel=11, mem_reg=0 → pc4.
- Channel 0 push {rd=7, 0xAB} while the pipeline is idle → written at cycle+1 with wb_src_out=1; lq_ready_out[0] stays 1.
- Both channels push at cycle 0 and the pipeline is idle → channel 0 written at cycle 1, channel 1 at cycle 2. Repeated: grants alternate.
- Continuous preq, channel 0 holding one entry, STARVE_LIMIT=4 → 4 pipeline writes. In the 5th cycle wb_stall_out=1 and channel 0 is written; the held pipeline write follows the next cycle.
- Fill channel 1 to LQ_DEPTH with the pipeline busy → lq_ready_out[1]=0. A valid pulse while full is not accepted. After one pop, ready=1 the next cycle. An rd=0 push leaves the occupancy unchanged.
- Assert rst with 2 entries buffered → after the edge all outputs are at reset values, no buffered write ever appears, and ready returns once rst is low.

Source files
------------

// File: rtl/wb_merge_unit_if.sv
// Writeback merge bus: MEM/WB pipeline fields, long-latency result
// channels, and the register-file write port.
interface wb_merge_unit_if #(
   parameter int XLEN   = 32,
   parameter int NUM_LQ = 2
);
   logic [XLEN-1:0]        wb_alu_out_in;
   logic [XLEN-1:0]        wb_mem_data_in;
   logic [XLEN-1:0]        wb_pc4_in;
   logic [XLEN-1:0]        wb_imm_in;
   logic [4:0]             wb_rd_in;
   logic [1:0]             wb_reg_in_sel_in;
   logic                   wb_mem_reg_in;
   logic [2:0]             wb_mem_funct3_in;
   logic [1:0]             wb_addr_lo_in;
   logic                   wb_reg_wr_in;
   logic [NUM_LQ-1:0]      lq_valid_in;
   logic [NUM_LQ*XLEN-1:0] lq_data_in;
   logic [NUM_LQ*5-1:0]    lq_rd_in;
   logic [NUM_LQ-1:0]      lq_ready_out;
   logic [4:0]             wb_rd_out;
   logic [XLEN-1:0]        wb_reg_wr_data_out;
   logic                   wb_reg_wr_out;
   logic [2:0]             wb_src_out;
   logic                   wb_stall_out;

   modport master (
      output wb_alu_out_in, wb_mem_data_in, wb_pc4_in, wb_imm_in, wb_rd_in,
             wb_reg_in_sel_in, wb_mem_reg_in, wb_mem_funct3_in, wb_addr_lo_in,
             wb_reg_wr_in, lq_valid_in, lq_data_in, lq_rd_in,
      input  lq_ready_out, wb_rd_out, wb_reg_wr_data_out, wb_reg_wr_out,
             wb_src_out, wb_stall_out
   );

   modport slave (
      input  wb_alu_out_in, wb_mem_data_in, wb_pc4_in, wb_imm_in, wb_rd_in,
             wb_reg_in_sel_in, wb_mem_reg_in, wb_mem_funct3_in, wb_addr_lo_in,
             wb_reg_wr_in, lq_valid_in, lq_data_in, lq_rd_in,
      output lq_ready_out, wb_rd_out, wb_reg_wr_data_out, wb_reg_wr_out,
             wb_src_out, wb_stall_out
   );
endinterface

// File: rtl/wb_merge_unit.sv
// Writeback merge stage: combines the in-order pipeline writeback with
// buffered long-latency results onto the single register-file write port,
// with round-robin channel draining and a one-cycle starvation stall.
module wb_merge_unit #(
   parameter int XLEN         = 32,
   parameter int NUM_LQ       = 2,
   parameter int LQ_DEPTH     = 2,
   parameter int STARVE_LIMIT = 4
) (
   input logic           clk,
   input logic           rst,
   wb_merge_unit_if.slave bus
);
   localparam int AW = $clog2(LQ_DEPTH);
   localparam int PW = (NUM_LQ > 1) ? $clog2(NUM_LQ) : 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [AW-1:0] PTR_ONE    = 1;
   localparam logic [AW:0]   CNT_ONE    = 1;
   localparam logic [AW:0]   CNT_FULL   = LQ_DEPTH;
   localparam logic [PW-1:0] RR_ONE     = 1;
   localparam logic [PW-1:0] RR_LAST    = NUM_LQ - 1;
   localparam logic [SW-1:0] STARVE_ONE = 1;
   localparam logic [SW-1:0] STARVE_MAX = STARVE_LIMIT;

   logic [XLEN-1:0]   head_data [NUM_LQ];
   logic [4:0]        head_rd   [NUM_LQ];
   logic [NUM_LQ-1:0] nonempty;
   logic [NUM_LQ-1:0] ready;
   logic [NUM_LQ-1:0] pop;
   logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
   logic              preq, any_ne, force_drain, pipe_win, grant_vld;
   logic [PW-1:0]     grant_idx;
   logic [XLEN-1:0]   pipe_data;
   int                cand;

   // RV32I sub-word load extraction; addr_lo[0] is ignored for halfwords
   function automatic logic [XLEN-1:0] extract_load(input logic [XLEN-1:0] word,
                                                    input logic [2:0] f3,
                                                    input logic [1:0] lo);
      logic [7:0]  b;
      logic [15:0] h;
      case (lo)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lo[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  return {{(XLEN-8){b[7]}}, b};
         3'b100:  return {{(XLEN-8){1'b0}}, b};
         3'b001:  return {{(XLEN-16){h[15]}}, h};
         3'b101:  return {{(XLEN-16){1'b0}}, h};
         default: return word;
      endcase
   endfunction

   // Pipeline write-data select (load data overrides reg_in_sel)
   always_comb begin
      pipe_data = bus.wb_alu_out_in;
      if (bus.wb_mem_reg_in) begin
         pipe_data = extract_load(bus.wb_mem_data_in, bus.wb_mem_funct3_in, bus.wb_addr_lo_in);
      end else begin
         case (bus.wb_reg_in_sel_in)
            2'b10:   pipe_data = bus.wb_imm_in;
            2'b11:   pipe_data = bus.wb_pc4_in;
            default: pipe_data = bus.wb_alu_out_in;
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LQ; gi++) begin : g_ch
         logic [XLEN-1:0] data_mem_q [LQ_DEPTH];
         logic [4:0]      rd_mem_q   [LQ_DEPTH];
         logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
         logic [AW:0]     cnt_q, cnt_d;
         logic [4:0]      in_rd;
         logic            store;

         // Ready reflects fullness only; a same-cycle pop does not free a slot.
         // rd=0 results are accepted but dropped since they never write.
         assign in_rd          = bus.lq_rd_in[gi*5 +: 5];
         assign ready[gi]      = !rst && (cnt_q != CNT_FULL);
         assign nonempty[gi]   = (cnt_q != '0);
         assign head_data[gi]  = data_mem_q[rptr_q];
         assign head_rd[gi]    = rd_mem_q[rptr_q];
         assign store          = bus.lq_valid_in[gi] && ready[gi] && (in_rd != 5'd0);

         // Next FIFO pointers and occupancy
         always_comb begin
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            cnt_d  = cnt_q;
            if (store)   wptr_d = wptr_q + PTR_ONE;
            if (pop[gi]) rptr_d = rptr_q + PTR_ONE;
            case ({store, pop[gi]})
               2'b10:   cnt_d = cnt_q + CNT_ONE;
               2'b01:   cnt_d = cnt_q - CNT_ONE;
               default: cnt_d = cnt_q;
            endcase
         end

         // FIFO pointer/occupancy registers; reset discards buffered entries
         always_ff @(posedge clk) begin
            if (rst) begin
               wptr_q <= '0;
               rptr_q <= '0;
               cnt_q  <= '0;
            end else begin
               wptr_q <= wptr_d;
               rptr_q <= rptr_d;
               cnt_q  <= cnt_d;
            end
         end

         // Entry storage; contents are don't-care until counted valid
         always_ff @(posedge clk) begin
            if (store) begin
               data_mem_q[wptr_q] <= bus.lq_data_in[gi*XLEN +: XLEN];
               rd_mem_q[wptr_q]   <= in_rd;
            end
         end
      end
   endgenerate

   // Arbitration: pipeline first unless starvation forces a channel drain
   always_comb begin
      preq        = bus.wb_reg_wr_in && (bus.wb_rd_in != 5'd0);
      any_ne      = |nonempty;
      force_drain = (starve_cnt_q == STARVE_MAX) && any_ne;
      pipe_win    = preq && !force_drain;
      grant_vld   = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      pop         = '0;
      if (!pipe_win && !rst) begin
         for (int k = 0; k < NUM_LQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_LQ) cand = cand - NUM_LQ;
            if (!grant_vld && nonempty[cand]) begin
               grant_vld = 1'b1;
               grant_idx = PW'(cand);
            end
         end
      end
      if (grant_vld) pop[grant_idx] = 1'b1;

      rr_ptr_d = rr_ptr_q;
      if (grant_vld) rr_ptr_d = (grant_idx == RR_LAST) ? '0 : grant_idx + RR_ONE;

      starve_cnt_d = starve_cnt_q;
      if (grant_vld || !any_ne)
         starve_cnt_d = '0;
      else if (pipe_win && starve_cnt_q != STARVE_MAX)
         starve_cnt_d = starve_cnt_q + STARVE_ONE;
   end

   // Register-file write port and handshake outputs
   always_comb begin
      bus.wb_rd_out          = bus.wb_rd_in;
      bus.wb_reg_wr_data_out = pipe_data;
      bus.wb_reg_wr_out      = 1'b0;
      bus.wb_src_out         = 3'd0;
      bus.wb_stall_out       = 1'b0;
      bus.lq_ready_out       = ready;
      if (!rst) begin
         bus.wb_stall_out = force_drain && preq;
         if (grant_vld) begin
            bus.wb_rd_out          = head_rd[grant_idx];
            bus.wb_reg_wr_data_out = head_data[grant_idx];
            bus.wb_reg_wr_out      = 1'b1;
            bus.wb_src_out         = 3'(grant_idx) + 3'd1;
         end else begin
            bus.wb_reg_wr_out = preq;
         end
      end
   end

   // Round-robin pointer and starvation counter
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q     <= '0;
         starve_cnt_q <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end
endmodule

// File: tb/tb_wb_merge_unit.sv
// Self-checking bench for wb_merge_unit: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_wb_merge_unit;
   localparam int XLEN         = 32;
   localparam int NUM_LQ       = 2;
   localparam int LQ_DEPTH     = 2;
   localparam int STARVE_LIMIT = 4;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_merge_unit_if #(.XLEN(XLEN), .NUM_LQ(NUM_LQ)) bus ();

   wb_merge_unit #(
      .XLEN(XLEN), .NUM_LQ(NUM_LQ), .LQ_DEPTH(LQ_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state
   ent_t mq [NUM_LQ][$];
   int   rr_m     = 0;
   int   starve_m = 0;
   bit   m_stall  = 0;

   // observed outputs of the last step
   logic              obs_wr, obs_stall;
   logic [4:0]        obs_rd;
   logic [31:0]       obs_data;
   logic [2:0]        obs_src;
   logic [NUM_LQ-1:0] obs_ready;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] lo);
      int unsigned b, h;
      b = (w >> (8 * lo)) & 32'hFF;
      h = (w >> (16 * lo[1])) & 32'hFFFF;
      case (f3)
         3'b000:  return (b >= 128) ? b - 256 : b;
         3'b100:  return b;
         3'b001:  return (h >= 32768) ? h - 65536 : h;
         3'b101:  return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] ref_pipe();
      if (bus.wb_mem_reg_in)
         return ref_load(bus.wb_mem_data_in, bus.wb_mem_funct3_in, bus.wb_addr_lo_in);
      case (bus.wb_reg_in_sel_in)
         2'b10:   return bus.wb_imm_in;
         2'b11:   return bus.wb_pc4_in;
         default: return bus.wb_alu_out_in;
      endcase
   endfunction

   task automatic pipe_idle();
      bus.wb_reg_wr_in     = 1'b0;
      bus.wb_rd_in         = 5'd0;
      bus.wb_alu_out_in    = '0;
      bus.wb_mem_data_in   = '0;
      bus.wb_pc4_in        = '0;
      bus.wb_imm_in        = '0;
      bus.wb_reg_in_sel_in = 2'b00;
      bus.wb_mem_reg_in    = 1'b0;
      bus.wb_mem_funct3_in = 3'b010;
      bus.wb_addr_lo_in    = 2'b00;
   endtask

   task automatic pipe_alu(input logic [4:0] rd, input logic [31:0] val);
      pipe_idle();
      bus.wb_reg_wr_in  = 1'b1;
      bus.wb_rd_in      = rd;
      bus.wb_alu_out_in = val;
   endtask

   task automatic push(input int ch, input logic [4:0] rd, input logic [31:0] data);
      bus.lq_valid_in[ch]            = 1'b1;
      bus.lq_rd_in[ch*5 +: 5]        = rd;
      bus.lq_data_in[ch*XLEN +: XLEN] = data;
   endtask

   task automatic no_push();
      bus.lq_valid_in = '0;
      bus.lq_rd_in    = '0;
      bus.lq_data_in  = '0;
   endtask

   // One clock cycle: sample at mid-cycle, compare with model, advance model.
   task automatic step();
      logic [NUM_LQ-1:0] rdy;
      bit                preq, any_ne, frc, exp_wr, exp_stall;
      int                g, idx, exp_src;
      logic [4:0]        exp_rd;
      logic [31:0]       exp_data;
      ent_t              e;
      #4;
      obs_wr    = bus.wb_reg_wr_out;
      obs_rd    = bus.wb_rd_out;
      obs_data  = bus.wb_reg_wr_data_out;
      obs_src   = bus.wb_src_out;
      obs_stall = bus.wb_stall_out;
      obs_ready = bus.lq_ready_out;
      if (rst) begin
         chk("rst_wr", obs_wr, 0);
         chk("rst_stall", obs_stall, 0);
         chk("rst_ready", obs_ready, 0);
         for (int i = 0; i < NUM_LQ; i++) mq[i].delete();
         rr_m = 0;
         starve_m = 0;
         m_stall = 0;
      end else begin
         any_ne = 0;
         for (int i = 0; i < NUM_LQ; i++) begin
            rdy[i] = (mq[i].size() < LQ_DEPTH);
            if (mq[i].size() > 0) any_ne = 1;
         end
         preq = bus.wb_reg_wr_in && (bus.wb_rd_in != 0);
         frc  = (starve_m == STARVE_LIMIT) && any_ne;
         g    = -1;
         if (!(preq && !frc)) begin
            for (int k = 0; k < NUM_LQ; k++) begin
               idx = (rr_m + k) % NUM_LQ;
               if (g < 0 && mq[idx].size() > 0) g = idx;
            end
         end
         if (g >= 0) begin
            exp_wr   = 1;
            exp_rd   = mq[g][0].rd;
            exp_data = mq[g][0].data;
            exp_src  = g + 1;
         end else begin
            exp_wr   = preq;
            exp_rd   = bus.wb_rd_in;
            exp_data = ref_pipe();
            exp_src  = 0;
         end
         exp_stall = frc && preq;
         chk("ready", obs_ready, rdy);
         chk("wr_en", obs_wr, exp_wr);
         chk("wr_rd", obs_rd, exp_rd);
         chk("wr_data", obs_data, exp_data);
         chk("stall", obs_stall, exp_stall);
         if (exp_wr) chk("src", obs_src, exp_src);
         if (g >= 0) begin
            void'(mq[g].pop_front());
            rr_m = (g + 1) % NUM_LQ;
         end
         if (g >= 0 || !any_ne) starve_m = 0;
         else if (starve_m < STARVE_LIMIT) starve_m++;
         for (int i = 0; i < NUM_LQ; i++) begin
            if (bus.lq_valid_in[i] && rdy[i] && bus.lq_rd_in[i*5 +: 5] != 0) begin
               e.rd   = bus.lq_rd_in[i*5 +: 5];
               e.data = bus.lq_data_in[i*XLEN +: XLEN];
               mq[i].push_back(e);
            end
         end
         m_stall = exp_stall;
      end
      $display("t=%0t rst=%0b wr=%0b x%0d=%h src=%0d stall=%0b ready=%b",
               $time, rst, obs_wr, obs_rd, obs_data, obs_src, obs_stall, obs_ready);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      pipe_idle();
      no_push();
      step();
      step();
      rst = 1'b0;

      // sub-word loads and pc4 select
      bus.wb_reg_wr_in     = 1'b1;
      bus.wb_rd_in         = 5'd5;
      bus.wb_mem_reg_in    = 1'b1;
      bus.wb_mem_funct3_in = 3'b000;
      bus.wb_addr_lo_in    = 2'd2;
      bus.wb_mem_data_in   = 32'h12F45678;
      step();
      chk("lb_data", obs_data, 32'hFFFFFFF4);
      chk("lb_rd", obs_rd, 5);
      bus.wb_mem_funct3_in = 3'b101;
      step();
      chk("lhu_data", obs_data, 32'h000012F4);
      bus.wb_mem_reg_in    = 1'b0;
      bus.wb_reg_in_sel_in = 2'b11;
      bus.wb_pc4_in        = 32'h00001004;
      step();
      chk("pc4_data", obs_data, 32'h00001004);

      // both channels push with idle pipeline: grants alternate 0,1
      pipe_idle();
      for (int r = 0; r < 2; r++) begin
         push(0, 5'(8 + r), 32'hA000 + r);
         push(1, 5'(10 + r), 32'hB000 + r);
         step();
         no_push();
         step();
         chk("rr_first", obs_src, 1);
         step();
         chk("rr_second", obs_src, 2);
      end

      // single channel-0 result, written one cycle after the push
      push(0, 5'd7, 32'h000000AB);
      step();
      no_push();
      step();
      chk("ch0_src", obs_src, 1);
      chk("ch0_data", obs_data, 32'h000000AB);
      chk("ch0_ready", obs_ready[0], 1);

      // starvation: 4 pipeline writes, then forced drain with stall
      push(0, 5'd9, 32'h0000C0DE);
      step();
      no_push();
      pipe_alu(5'd3, 32'h55);
      for (int c = 0; c < STARVE_LIMIT; c++) begin
         step();
         chk("starve_pipe_src", obs_src, 0);
         chk("starve_pipe_stall", obs_stall, 0);
      end
      step();
      chk("force_stall", obs_stall, 1);
      chk("force_src", obs_src, 1);
      chk("force_data", obs_data, 32'h0000C0DE);
      step();
      chk("held_wr", obs_wr, 1);
      chk("held_src", obs_src, 0);
      chk("held_stall", obs_stall, 0);

      // fill channel 1 while the pipeline is busy
      push(1, 5'd12, 32'h111);
      step();
      push(1, 5'd13, 32'h222);
      step();
      push(1, 5'd14, 32'h333);
      step();
      chk("full_ready", obs_ready[1], 0);
      no_push();
      step();
      step();
      step();
      chk("full_force_stall", obs_stall, 1);
      chk("full_force_data", obs_data, 32'h111);
      push(1, 5'd0, 32'hDEAD);
      step();
      chk("after_pop_ready", obs_ready[1], 1);
      push(1, 5'd15, 32'h444);
      step();
      no_push();
      step();
      chk("refull_ready", obs_ready[1], 0);
      pipe_idle();
      repeat (3) step();

      // reset with two buffered entries discards them
      pipe_alu(5'd4, 32'h77);
      push(0, 5'd16, 32'h616);
      push(1, 5'd17, 32'h717);
      step();
      no_push();
      rst = 1'b1;
      step();
      rst = 1'b0;
      pipe_idle();
      repeat (4) begin
         step();
         chk("post_rst_wr", obs_wr, 0);
      end
      chk("post_rst_ready", obs_ready, 2'b11);

      // randomized traffic
      repeat (800) begin
         if (!m_stall) begin
            bus.wb_reg_wr_in     = ($urandom_range(0, 9) < 6);
            bus.wb_rd_in         = 5'($urandom_range(0, 31));
            bus.wb_alu_out_in    = $urandom;
            bus.wb_mem_data_in   = $urandom;
            bus.wb_pc4_in        = $urandom;
            bus.wb_imm_in        = $urandom;
            bus.wb_reg_in_sel_in = 2'($urandom_range(0, 3));
            bus.wb_mem_reg_in    = 1'($urandom_range(0, 1));
            bus.wb_mem_funct3_in = 3'($urandom_range(0, 7));
            bus.wb_addr_lo_in    = 2'($urandom_range(0, 3));
         end
         for (int i = 0; i < NUM_LQ; i++) begin
            bus.lq_valid_in[i]              = ($urandom_range(0, 9) < 3);
            bus.lq_rd_in[i*5 +: 5]          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.lq_data_in[i*XLEN +: XLEN]  = $urandom;
         end
         rst = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
